// File: rtl/cdb_writeback_arbiter_if.sv
// FU result / CDB broadcast bundle for the writeback arbiter.
// master = FU/RS side, slave = arbiter.
interface cdb_writeback_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  localparam int SW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic                     flush;
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU*TAG_W-1:0]  fu_tag;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]        fu_space;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [SW-1:0]            cdb_src;
  logic                     overflow;

  modport master (
    output flush, fu_valid, fu_tag, fu_data,
    input  fu_space, cdb_valid, cdb_tag,
    input  cdb_data, cdb_src, overflow
  );

  modport slave (
    input  flush, fu_valid, fu_tag, fu_data,
    output fu_space, cdb_valid, cdb_tag,
    output cdb_data, cdb_src, overflow
  );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Per-FU result FIFOs, round-robin onto a registered CDB.
// Define CDB_BYPASS_EN to let an empty FIFO forward its input directly.
module cdb_writeback_arbiter #(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input logic clk,
  input logic rst,
  cdb_writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HWM  = CW'(DEPTH - 2);
  localparam logic [SW-1:0] LAST = SW'(NUM_FU - 1);

  logic [TAG_W-1:0]  tag_mem  [NUM_FU][DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_FU][DEPTH];
  logic [PW-1:0]     rd_ptr   [NUM_FU];
  logic [PW-1:0]     wr_ptr   [NUM_FU];
  logic [CW-1:0]     cnt      [NUM_FU];
  logic [CW-1:0]     cnt_nxt  [NUM_FU];
  logic [TAG_W-1:0]  cand_tag  [NUM_FU];
  logic [DATA_W-1:0] cand_data [NUM_FU];

  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] byp;
  logic [NUM_FU-1:0] byp_req;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] wr_en;
  logic [NUM_FU-1:0] space_q;

  logic [SW-1:0]     rr;
  logic [SW-1:0]     rr_nxt;
  logic [SW-1:0]     win;
  logic              grant_any;
  logic              ovf_set;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SW-1:0]     cdb_src_q;
  logic              overflow_q;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      empty[i] = (cnt[i] == '0);
      push[i]  = bus.fu_valid[i] && !bus.flush;
    end
  end

`ifdef CDB_BYPASS_EN
  // Empty FIFO presents its live input as the grant candidate.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      byp_req[i] = push[i] && empty[i];
      if (empty[i]) begin
        cand_tag[i]  = bus.fu_tag[i*TAG_W +: TAG_W];
        cand_data[i] = bus.fu_data[i*DATA_W +: DATA_W];
      end else begin
        cand_tag[i]  = tag_mem[i][rd_ptr[i]];
        cand_data[i] = data_mem[i][rd_ptr[i]];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      byp_req[i]   = 1'b0;
      cand_tag[i]  = tag_mem[i][rd_ptr[i]];
      cand_data[i] = data_mem[i][rd_ptr[i]];
    end
  end
`endif

  assign req = ~empty | byp_req;

  // First requester at or after rr, wrapping.
  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    win       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_FU) j = j - NUM_FU;
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        win       = SW'(j);
      end
    end
  end

  assign rr_nxt = (win == LAST) ? '0 : win + SW'(1);

  always_comb begin
    ovf_set = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i]   = grant_any && (win == SW'(i)) && !empty[i];
      byp[i]   = grant_any && (win == SW'(i)) && empty[i];
      wr_en[i] = push[i] && !byp[i]
              && ((cnt[i] != FULL) || pop[i]);
      if (push[i] && (cnt[i] == FULL) && !pop[i])
        ovf_set = 1'b1;
      cnt_nxt[i] = cnt[i] + CW'(wr_en[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (wr_en[i]) begin
        tag_mem[i][wr_ptr[i]]  <= bus.fu_tag[i*TAG_W +: TAG_W];
        data_mem[i][wr_ptr[i]] <= bus.fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr          <= '0;
      space_q     <= '1;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      overflow_q  <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr          <= '0;
      space_q     <= '1;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + PW'(1);
        cnt[i]     <= cnt_nxt[i];
        // One slot kept free for a result already in the FU.
        space_q[i] <= (cnt_nxt[i] <= HWM);
      end
      cdb_valid_q <= grant_any;
      if (grant_any) begin
        rr         <= rr_nxt;
        cdb_tag_q  <= cand_tag[win];
        cdb_data_q <= cand_data[win];
        cdb_src_q  <= win;
      end
      if (ovf_set) overflow_q <= 1'b1;
    end
  end

  assign bus.fu_space  = space_q;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_cdb_writeback_arbiter;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int DW = 32;
  localparam int TW = 6;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_writeback_arbiter_if #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) bus();

  cdb_writeback_arbiter #(
    .NUM_FU(N), .DEPTH(D), .DATA_W(DW), .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [37:0] mq [N][$];
  int          mrr;
  logic        ev;
  logic [5:0]  etag;
  logic [31:0] edata;
  logic [1:0]  esrc;
  logic        eovf;
  logic [3:0]  esp;

  typedef struct {
    logic [3:0]  fv;
    logic [5:0]  tg;
    logic [31:0] dt;
    logic        ev;
    logic [1:0]  src;
    logic [5:0]  tag;
    logic [31:0] dat;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) mq[i].delete();
    mrr = 0; ev = 0; etag = 0; edata = 0; esrc = 0;
    eovf = 0; esp = 4'hF;
  endtask

  // Queue model of one clock edge.
  task automatic mstep(input logic [3:0] fv, input logic [23:0] tg,
                       input logic [127:0] dt, input logic fl);
    int w;
    int bt;
    w = -1;
    bt = -1;
    if (fl) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mrr = 0; ev = 0; esp = 4'hF;
      return;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mrr + k) % N;
      if (w < 0 && (mq[j].size() > 0 || (BYP && fv[j]))) w = j;
    end
    ev = (w >= 0);
    if (w >= 0) begin
      esrc = 2'(w);
      if (mq[w].size() > 0) begin
        logic [37:0] e;
        e = mq[w].pop_front();
        etag = e[37:32];
        edata = e[31:0];
      end else begin
        etag = tg[w*6 +: 6];
        edata = dt[w*32 +: 32];
        bt = w;
      end
      mrr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (fv[i] && i != bt) begin
        if (mq[i].size() < D) mq[i].push_back({tg[i*6 +: 6], dt[i*32 +: 32]});
        else eovf = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) esp[i] = (mq[i].size() <= D - 2);
  endtask

  task automatic chk_all();
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(ev));
    chk("cdb_tag",   64'(bus.cdb_tag),   64'(etag));
    chk("cdb_data",  64'(bus.cdb_data),  64'(edata));
    chk("cdb_src",   64'(bus.cdb_src),   64'(esrc));
    chk("fu_space",  64'(bus.fu_space),  64'(esp));
    chk("overflow",  64'(bus.overflow),  64'(eovf));
  endtask

  task automatic cyc(input logic [3:0] fv_in, input logic [23:0] tg,
                     input logic [127:0] dt, input logic fl,
                     input logic gate);
    logic [3:0] fv;
    @(negedge clk);
    fv = gate ? (fv_in & bus.fu_space) : fv_in;
    bus.fu_valid = fv;
    bus.fu_tag   = tg;
    bus.fu_data  = dt;
    bus.flush    = fl;
    mstep(fv, tg, dt, fl);
    @(posedge clk);
    #1;
    chk_all();
  endtask

  function automatic logic [23:0] mk_tag(input logic [5:0] b);
    logic [23:0] r;
    for (int i = 0; i < N; i++) r[i*6 +: 6] = b + 6'(i);
    return r;
  endfunction

  function automatic logic [127:0] mk_dat(input logic [31:0] b);
    logic [127:0] r;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = b + 32'(i);
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 24'h0, 128'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic saw0;
    bus.fu_valid = '0;
    bus.fu_tag   = '0;
    bus.fu_data  = '0;
    bus.flush    = 1'b0;

`ifdef CDB_BYPASS_EN
    tbl[0]  = '{4'b0100, 6'h13, 32'hDEADBEED, 1, 2, 6'h15, 32'hDEADBEEF};
    tbl[1]  = '{4'b0000, 6'h00, 32'h0,        0, 0, 6'h00, 32'h0};
    tbl[2]  = '{4'b1000, 6'h20, 32'h1,        1, 3, 6'h23, 32'h4};
    tbl[3]  = '{4'b0000, 6'h00, 32'h0,        0, 0, 6'h00, 32'h0};
    tbl[4]  = '{4'b1111, 6'h00, 32'hA0000000, 1, 0, 6'h00, 32'hA0000000};
    tbl[5]  = '{4'b0000, 6'h00, 32'h0,        1, 1, 6'h01, 32'hA0000001};
    tbl[6]  = '{4'b0000, 6'h00, 32'h0,        1, 2, 6'h02, 32'hA0000002};
    tbl[7]  = '{4'b0000, 6'h00, 32'h0,        1, 3, 6'h03, 32'hA0000003};
    tbl[8]  = '{4'b0010, 6'h2F, 32'h55,       1, 1, 6'h30, 32'h56};
    tbl[9]  = '{4'b0000, 6'h00, 32'h0,        0, 0, 6'h00, 32'h0};
    tbl[10] = '{4'b0000, 6'h00, 32'h0,        0, 0, 6'h00, 32'h0};
`else
    tbl[0]  = '{4'b0100, 6'h13, 32'hDEADBEED, 0, 0, 6'h00, 32'h0};
    tbl[1]  = '{4'b0000, 6'h00, 32'h0,        1, 2, 6'h15, 32'hDEADBEEF};
    tbl[2]  = '{4'b1000, 6'h20, 32'h1,        0, 0, 6'h00, 32'h0};
    tbl[3]  = '{4'b0000, 6'h00, 32'h0,        1, 3, 6'h23, 32'h4};
    tbl[4]  = '{4'b1111, 6'h00, 32'hA0000000, 0, 0, 6'h00, 32'h0};
    tbl[5]  = '{4'b0000, 6'h00, 32'h0,        1, 0, 6'h00, 32'hA0000000};
    tbl[6]  = '{4'b0000, 6'h00, 32'h0,        1, 1, 6'h01, 32'hA0000001};
    tbl[7]  = '{4'b0000, 6'h00, 32'h0,        1, 2, 6'h02, 32'hA0000002};
    tbl[8]  = '{4'b0010, 6'h2F, 32'h55,       1, 3, 6'h03, 32'hA0000003};
    tbl[9]  = '{4'b0000, 6'h00, 32'h0,        1, 1, 6'h30, 32'h56};
    tbl[10] = '{4'b0000, 6'h00, 32'h0,        0, 0, 6'h00, 32'h0};
`endif

    // Async reset from power-up, checked before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.cdb_valid), 64'h0);
    chk("rst_space", 64'(bus.fu_space),  64'hF);
    chk("rst_ovf",   64'(bus.overflow),  64'h0);
    chk("rst_src",   64'(bus.cdb_src),   64'h0);
    mreset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Vector table: single result and round-robin order.
    for (int r = 0; r < 11; r++) begin
      cyc(tbl[r].fv, mk_tag(tbl[r].tg), mk_dat(tbl[r].dt), 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", r), 64'(bus.cdb_valid), 64'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d_src", r),  64'(bus.cdb_src),  64'(tbl[r].src));
        chk($sformatf("tbl%0d_tag", r),  64'(bus.cdb_tag),  64'(tbl[r].tag));
        chk($sformatf("tbl%0d_data", r), 64'(bus.cdb_data), 64'(tbl[r].dat));
      end
      chk($sformatf("tbl%0d_space", r), 64'(bus.fu_space), 64'hF);
    end

    // Backpressure: every FU pulses whenever its space flag allows.
    saw0 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cyc(4'hF, mk_tag(6'(c)), mk_dat(32'(c) << 8), 1'b0, 1'b1);
      if (!bus.fu_space[0]) saw0 = 1'b1;
    end
    chk("bp_space0_dropped", 64'(saw0), 64'h1);
    chk("bp_no_ovf", 64'(bus.overflow), 64'h0);
    cyc(4'h0, 24'h0, 128'h0, 1'b1, 1'b0);

    // Flush with entries queued and a same-cycle FU1 result.
    cyc(4'b0111, mk_tag(6'h08), mk_dat(32'h100), 1'b0, 1'b0);
    cyc(4'b0010, mk_tag(6'h3A), mk_dat(32'h777), 1'b1, 1'b0);
    chk("flush_valid", 64'(bus.cdb_valid), 64'h0);
    chk("flush_space", 64'(bus.fu_space),  64'hF);
    for (int c = 0; c < 3; c++) begin
      idle(1);
      chk("flush_no_result", 64'(bus.cdb_valid), 64'h0);
    end

    // Overflow: flood all FIFOs well beyond capacity.
    for (int c = 0; c < 8; c++)
      cyc(4'hF, mk_tag(6'h10), mk_dat(32'(c)), 1'b0, 1'b0);
    chk("ovf_set", 64'(bus.overflow), 64'h1);
    cyc(4'h0, 24'h0, 128'h0, 1'b1, 1'b0);
    chk("ovf_sticky_flush", 64'(bus.overflow), 64'h1);
    idle(2);
    chk("ovf_sticky_idle", 64'(bus.overflow), 64'h1);

    // Reset mid-operation, between clock edges.
    for (int c = 0; c < 3; c++)
      cyc(4'hF, mk_tag(6'h20), mk_dat(32'h40), 1'b0, 1'b0);
    @(negedge clk);
    bus.fu_valid = '0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.cdb_valid), 64'h0);
    chk("mid_rst_space", 64'(bus.fu_space),  64'hF);
    chk("mid_rst_ovf",   64'(bus.overflow),  64'h0);
    mreset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Random traffic honouring fu_space: never overflows.
    for (int c = 0; c < 300; c++)
      cyc(4'($urandom), 24'($urandom),
          {$urandom, $urandom, $urandom, $urandom},
          ($urandom_range(0, 31) == 0), 1'b1);
    chk("rand_gated_no_ovf", 64'(bus.overflow), 64'h0);

    // Random traffic ignoring fu_space.
    for (int c = 0; c < 300; c++)
      cyc(4'($urandom), 24'($urandom),
          {$urandom, $urandom, $urandom, $urandom},
          ($urandom_range(0, 31) == 0), 1'b0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
